// File: rtl/sirv_param_queue_pkg.sv
// Shared helpers for the parameterised peripheral queue: pointer and count sizing.
package sirv_param_queue_pkg;

  // Pointer width never drops below one bit so DEPTH=1 still has a legal register.
  function automatic int qptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int qcnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sirv_queue_ptr.sv
// Wrap-at-MAX pointer: advances on inc, returns to zero after MAX so any depth works.
module sirv_queue_ptr #(
  parameter int MAX = 1,
  parameter int W   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] ptr_d, ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (inc) ptr_d = (ptr_q == MAX_V) ? '0 : ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/sirv_param_queue.sv
// Parameterised ready/valid FIFO with optional pipe (replace-when-full) and flow (empty bypass).
module sirv_param_queue #(
  parameter int DW    = 32,
  parameter int DEPTH = 2,
  parameter int PIPE  = 1,
  parameter int FLOW  = 0,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enq_valid,
  output logic          enq_ready,
  input  logic [DW-1:0] enq_data,
  output logic          deq_valid,
  input  logic          deq_ready,
  output logic [DW-1:0] deq_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  import sirv_param_queue_pkg::*;

  localparam int PW = qptr_w(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] enq_ptr, deq_ptr;
  logic          maybe_full_d, maybe_full_q;
  logic          ptr_match, do_enq, do_deq, bypass, wr_en, rd_en;
  logic          pipe_en, flow_en;
  logic [DW-1:0] head_data;

  assign pipe_en   = (PIPE != 0);
  assign flow_en   = (FLOW != 0);
  assign ptr_match = (enq_ptr == deq_ptr);
  assign empty     = ptr_match & ~maybe_full_q;
  assign full      = ptr_match & maybe_full_q;
  assign enq_ready = ~full | (pipe_en & deq_ready);
  assign deq_valid = ~empty | (flow_en & enq_valid);
  assign do_enq    = enq_valid & enq_ready;
  assign do_deq    = deq_valid & deq_ready;

  // A flow-through transfer is neither a write nor a read of storage.
  assign bypass = flow_en & empty & enq_valid & deq_ready;
  assign wr_en  = do_enq & ~bypass;
  assign rd_en  = do_deq & ~bypass;

  sirv_queue_ptr #(.MAX(DEPTH - 1), .W(PW)) u_enq_ptr (
    .clk(clk), .rst_n(rst_n), .inc(wr_en), .ptr(enq_ptr)
  );

  sirv_queue_ptr #(.MAX(DEPTH - 1), .W(PW)) u_deq_ptr (
    .clk(clk), .rst_n(rst_n), .inc(rd_en), .ptr(deq_ptr)
  );

  always_comb begin
    maybe_full_d = maybe_full_q;
    if (wr_en != rd_en) maybe_full_d = wr_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) maybe_full_q <= 1'b0;
    else        maybe_full_q <= maybe_full_d;
  end

  // Storage is intentionally unreset; decode by compare keeps any DEPTH index-safe.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++)
      if (wr_en && enq_ptr == PW'(i)) mem_q[i] <= enq_data;
  end

  always_comb begin
    head_data = mem_q[0];
    for (int i = 0; i < DEPTH; i++)
      if (deq_ptr == PW'(i)) head_data = mem_q[i];
  end

  assign deq_data = (flow_en && empty) ? enq_data : head_data;

  always_comb begin
    if (full)                    count = CW'(DEPTH);
    else if (enq_ptr >= deq_ptr) count = CW'(enq_ptr - deq_ptr);
    else                         count = CW'(DEPTH) - CW'(deq_ptr) + CW'(enq_ptr);
  end

`ifdef ASSERT_ON
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(do_enq && full && !(pipe_en && deq_ready)))
        else $error("enqueue accepted while full");
      assert (!(do_deq && !deq_valid))
        else $error("dequeue without valid data");
    end
  end
`endif

endmodule

// File: tb/tb_sirv_param_queue.sv
// Directed bench for sirv_param_queue across depth/pipe/flow configurations.
module tb_sirv_param_queue;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // A: DEPTH=3 PIPE=1, B: DEPTH=3 PIPE=0, C: DEPTH=2 FLOW=1, D: DEPTH=1 PIPE=1 (legacy)
  logic       ev_a = 0, er_a, dv_a, dr_a = 0, fl_a, em_a;
  logic [7:0] ed_a = 0, dd_a;
  logic [1:0] cnt_a;
  logic       ev_b = 0, er_b, dv_b, dr_b = 0, fl_b, em_b;
  logic [7:0] ed_b = 0, dd_b;
  logic [1:0] cnt_b;
  logic       ev_c = 0, er_c, dv_c, dr_c = 0, fl_c, em_c;
  logic [7:0] ed_c = 0, dd_c;
  logic [1:0] cnt_c;
  logic       ev_d = 0, er_d, dv_d, dr_d = 0, fl_d, em_d;
  logic [7:0] ed_d = 0, dd_d;
  logic [0:0] cnt_d;

  sirv_param_queue #(.DW(8), .DEPTH(3), .PIPE(1), .FLOW(0)) u_a (
    .clk(clk), .rst_n(rst_n), .enq_valid(ev_a), .enq_ready(er_a), .enq_data(ed_a),
    .deq_valid(dv_a), .deq_ready(dr_a), .deq_data(dd_a), .count(cnt_a), .full(fl_a), .empty(em_a));
  sirv_param_queue #(.DW(8), .DEPTH(3), .PIPE(0), .FLOW(0)) u_b (
    .clk(clk), .rst_n(rst_n), .enq_valid(ev_b), .enq_ready(er_b), .enq_data(ed_b),
    .deq_valid(dv_b), .deq_ready(dr_b), .deq_data(dd_b), .count(cnt_b), .full(fl_b), .empty(em_b));
  sirv_param_queue #(.DW(8), .DEPTH(2), .PIPE(1), .FLOW(1)) u_c (
    .clk(clk), .rst_n(rst_n), .enq_valid(ev_c), .enq_ready(er_c), .enq_data(ed_c),
    .deq_valid(dv_c), .deq_ready(dr_c), .deq_data(dd_c), .count(cnt_c), .full(fl_c), .empty(em_c));
  sirv_param_queue #(.DW(8), .DEPTH(1), .PIPE(1), .FLOW(0)) u_d (
    .clk(clk), .rst_n(rst_n), .enq_valid(ev_d), .enq_ready(er_d), .enq_data(ed_d),
    .deq_valid(dv_d), .deq_ready(dr_d), .deq_data(dd_d), .count(cnt_d), .full(fl_d), .empty(em_d));

  int npass = 0;
  int ntot  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  logic [7:0] q[$];
  logic       exp_rdy;

  initial begin
    // Reset values on every configuration
    #2;
    chk("rst_a_count", cnt_a, 0);
    chk("rst_a_empty", em_a, 1);
    chk("rst_a_full", fl_a, 0);
    chk("rst_a_deq_valid", dv_a, 0);
    chk("rst_a_enq_ready", er_a, 1);
    chk("rst_d_empty", em_d, 1);
    chk("rst_b_enq_ready", er_b, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Async reset mid-burst with two entries held
    ev_a = 1; ed_a = 8'h11; tick();
    ed_a = 8'h12; tick();
    #1;
    chk("burst_count2", cnt_a, 2);
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", cnt_a, 0);
    chk("async_rst_empty", em_a, 1);
    chk("async_rst_deq_valid", dv_a, 0);
    chk("async_rst_enq_ready", er_a, 1);
    ev_a = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Fill DEPTH=3 then drain in order
    ev_a = 1; ed_a = 8'hA1; tick();
    #1;
    chk("fill_count1", cnt_a, 1);
    chk("fill_deq_valid", dv_a, 1);
    ed_a = 8'hA2; tick();
    ed_a = 8'hA3; tick();
    ev_a = 0;
    #1;
    chk("fill_full", fl_a, 1);
    chk("fill_enq_ready", er_a, 0);
    chk("fill_count3", cnt_a, 3);
    dr_a = 1;
    #1;
    chk("drain_0", dd_a, 8'hA1); tick();
    chk("drain_1", dd_a, 8'hA2); tick();
    chk("drain_2", dd_a, 8'hA3); tick();
    chk("drain_empty", em_a, 1);
    chk("drain_count0", cnt_a, 0);
    dr_a = 0;

    // Interleaved traffic wraps both pointers through 2->0
    for (int i = 0; i < 10; i++) begin
      ev_a = 1; ed_a = 8'(8'h10 + i); dr_a = (i >= 2);
      #1;
      chk("wrap_count", cnt_a, (i < 2) ? i : 2);
      if (i >= 2) chk("wrap_data", dd_a, 8'(8'h10 + i - 2));
      tick();
    end
    ev_a = 0; dr_a = 1;
    #1;
    chk("wrap_tail0", dd_a, 8'h18); tick();
    chk("wrap_tail1", dd_a, 8'h19); tick();
    chk("wrap_empty", em_a, 1);
    dr_a = 0;

    // PIPE=1 full: replace head with 0x55 in one cycle
    ev_a = 1; ed_a = 8'hB1; tick();
    ed_a = 8'hB2; tick();
    ed_a = 8'hB3; tick();
    ed_a = 8'h55; dr_a = 1;
    #1;
    chk("pipe_enq_ready", er_a, 1);
    chk("pipe_head", dd_a, 8'hB1);
    tick();
    ev_a = 0;
    #1;
    chk("pipe_count", cnt_a, 3);
    chk("pipe_full", fl_a, 1);
    chk("pipe_q0", dd_a, 8'hB2); tick();
    chk("pipe_q1", dd_a, 8'hB3); tick();
    chk("pipe_q2", dd_a, 8'h55); tick();
    chk("pipe_empty", em_a, 1);
    dr_a = 0;

    // PIPE=0 full: enqueue blocked even with deq_ready
    ev_b = 1; ed_b = 8'hC1; tick();
    ed_b = 8'hC2; tick();
    ed_b = 8'hC3; tick();
    ed_b = 8'h55; dr_b = 1;
    #1;
    chk("nopipe_enq_ready", er_b, 0);
    chk("nopipe_head", dd_b, 8'hC1);
    tick();
    ev_b = 0; dr_b = 0;
    #1;
    chk("nopipe_count", cnt_b, 2);

    // FLOW=1 bypass when empty
    ev_c = 1; dr_c = 1; ed_c = 8'h77;
    #1;
    chk("flow_deq_valid", dv_c, 1);
    chk("flow_deq_data", dd_c, 8'h77);
    chk("flow_count", cnt_c, 0);
    tick();
    chk("flow_after_count", cnt_c, 0);
    chk("flow_after_empty", em_c, 1);
    dr_c = 0; ed_c = 8'h78;
    #1;
    chk("flow_nordy_data", dd_c, 8'h78);
    tick();
    ev_c = 0;
    #1;
    chk("flow_stored_count", cnt_c, 1);
    chk("flow_stored_data", dd_c, 8'h78);

    // Legacy 1-entry queue against a scoreboard
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      ev_d = 1'($urandom_range(0, 1));
      dr_d = 1'($urandom_range(0, 1));
      ed_d = 8'($urandom);
      #1;
      exp_rdy = (q.size() == 0) || dr_d;
      chk("d1_enq_ready", er_d, exp_rdy);
      chk("d1_deq_valid", dv_d, q.size() != 0);
      chk("d1_count", cnt_d, q.size());
      if (q.size() != 0) chk("d1_deq_data", dd_d, q[0]);
      if (dr_d && q.size() != 0) void'(q.pop_front());
      if (ev_d && exp_rdy) q.push_back(ed_d);
      tick();
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
